aximm_client: RTL

AXIMM_CLIENT -- requirements
Module: aximm_client

---
 rtl/aximm_client.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/aximm_client.sv
// Single-outstanding AXI4 memory-mapped client: one command becomes one
// single-beat AXI write or read, and its outcome is returned as one completion.
module aximm_client #(
    parameter int AXI4_IDW       = 8,
    parameter int AXI4_ADDRW     = 64,
    parameter int AXI4_LENW      = 8,
    parameter int AXI4_SIZEW     = 3,
    parameter int AXI4_BURSTW    = 2,
    parameter int AXI4_USERW     = 64,
    parameter int AXI4_MAX_DATAW = 512,
    parameter int AXI4_RESPW     = 2,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TOW            = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [AXI4_ADDRW-1:0]     req_addr,
    input  logic [AXI4_MAX_DATAW-1:0] req_data,
    input  logic [AXI4_USERW-1:0]     req_user,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [AXI4_MAX_DATAW-1:0] rsp_data,
    output logic [AXI4_RESPW-1:0]     rsp_resp,
    output logic [AXI4_USERW-1:0]     rsp_user,
    output logic                      aximm_client_awvalid,
    input  logic                      aximm_client_awready,
    output logic [AXI4_IDW-1:0]       aximm_client_awid,
    output logic [AXI4_ADDRW-1:0]     aximm_client_awaddr,
    output logic [AXI4_LENW-1:0]      aximm_client_awlen,
    output logic [AXI4_SIZEW-1:0]     aximm_client_awsize,
    output logic [AXI4_BURSTW-1:0]    aximm_client_awburst,
    output logic [AXI4_USERW-1:0]     aximm_client_awuser,
    output logic                      aximm_client_wvalid,
    input  logic                      aximm_client_wready,
    output logic [AXI4_IDW-1:0]       aximm_client_wid,
    output logic [AXI4_MAX_DATAW-1:0] aximm_client_wdata,
    output logic                      aximm_client_wlast,
    output logic [AXI4_USERW-1:0]     aximm_client_wuser,
    input  logic                      aximm_client_bvalid,
    output logic                      aximm_client_bready,
    input  logic [AXI4_IDW-1:0]       aximm_client_bid,
    input  logic [AXI4_RESPW-1:0]     aximm_client_bresp,
    input  logic [AXI4_USERW-1:0]     aximm_client_buser,
    output logic                      aximm_client_arvalid,
    input  logic                      aximm_client_arready,
    output logic [AXI4_IDW-1:0]       aximm_client_arid,
    output logic [AXI4_ADDRW-1:0]     aximm_client_araddr,
    output logic [AXI4_LENW-1:0]      aximm_client_arlen,
    output logic [AXI4_SIZEW-1:0]     aximm_client_arsize,
    output logic [AXI4_BURSTW-1:0]    aximm_client_arburst,
    output logic [AXI4_USERW-1:0]     aximm_client_aruser,
    input  logic                      aximm_client_rvalid,
    output logic                      aximm_client_rready,
    input  logic [AXI4_IDW-1:0]       aximm_client_rid,
    input  logic [AXI4_MAX_DATAW-1:0] aximm_client_rdata,
    input  logic [AXI4_RESPW-1:0]     aximm_client_rresp,
    input  logic                      aximm_client_rlast,
    input  logic [AXI4_USERW-1:0]     aximm_client_ruser
);

    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, RSP} state_t;

    localparam logic [AXI4_RESPW-1:0] RESP_SLVERR  = AXI4_RESPW'(2'b10);
    localparam logic [AXI4_RESPW-1:0] RESP_TIMEOUT = AXI4_RESPW'(2'b11);
    localparam logic [TOW-1:0]        TO_LAST      = TOW'(TIMEOUT_CYCLES - 1);

    state_t                    state;
    logic [AXI4_ADDRW-1:0]     addr_r;
    logic [AXI4_MAX_DATAW-1:0] data_r;
    logic [AXI4_USERW-1:0]     user_r;
    logic [TOW-1:0]            to_cnt;
    logic                      to_hit;
    logic                      unused_ids;

    // A single-beat read that does not close the burst is a protocol error.
    function automatic logic [AXI4_RESPW-1:0] read_resp(input logic last,
                                                        input logic [AXI4_RESPW-1:0] resp);
        return last ? resp : RESP_SLVERR;
    endfunction

    assign to_hit     = (to_cnt == TO_LAST);
    assign unused_ids = ^{aximm_client_bid, aximm_client_rid};

    assign aximm_client_awid    = '0;
    assign aximm_client_awaddr  = addr_r;
    assign aximm_client_awlen   = '0;
    assign aximm_client_awsize  = AXI4_SIZEW'(3'b110);
    assign aximm_client_awburst = AXI4_BURSTW'(2'b01);
    assign aximm_client_awuser  = user_r;
    assign aximm_client_wid     = '0;
    assign aximm_client_wdata   = data_r;
    assign aximm_client_wlast   = 1'b1;
    assign aximm_client_wuser   = user_r;
    assign aximm_client_arid    = '0;
    assign aximm_client_araddr  = addr_r;
    assign aximm_client_arlen   = '0;
    assign aximm_client_arsize  = AXI4_SIZEW'(3'b110);
    assign aximm_client_arburst = AXI4_BURSTW'(2'b01);
    assign aximm_client_aruser  = user_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                <= IDLE;
            req_ready            <= 1'b0;
            rsp_valid            <= 1'b0;
            rsp_write            <= 1'b0;
            rsp_data             <= '0;
            rsp_resp             <= '0;
            rsp_user             <= '0;
            aximm_client_awvalid <= 1'b0;
            aximm_client_wvalid  <= 1'b0;
            aximm_client_bready  <= 1'b0;
            aximm_client_arvalid <= 1'b0;
            aximm_client_rready  <= 1'b0;
            addr_r               <= '0;
            data_r               <= '0;
            user_r               <= '0;
            to_cnt               <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        addr_r    <= req_addr;
                        data_r    <= req_data;
                        user_r    <= req_user;
                        rsp_write <= req_write;
                        if (req_write) begin
                            aximm_client_awvalid <= 1'b1;
                            state                <= AW;
                        end else begin
                            aximm_client_arvalid <= 1'b1;
                            state                <= AR;
                        end
                    end
                end
                AW: if (aximm_client_awready) begin
                    aximm_client_awvalid <= 1'b0;
                    aximm_client_wvalid  <= 1'b1;
                    state                <= W;
                end
                W: if (aximm_client_wready) begin
                    aximm_client_wvalid <= 1'b0;
                    aximm_client_bready <= 1'b1;
                    to_cnt              <= '0;
                    state               <= B;
                end
                B: begin
                    if (aximm_client_bvalid) begin
                        aximm_client_bready <= 1'b0;
                        rsp_data            <= '0;
                        rsp_resp            <= aximm_client_bresp;
                        rsp_user            <= aximm_client_buser;
                        rsp_valid           <= 1'b1;
                        state               <= RSP;
                    end else begin
                        to_cnt <= to_cnt + TOW'(1);
                        if (to_hit) begin
                            aximm_client_bready <= 1'b0;
                            rsp_data            <= '0;
                            rsp_resp            <= RESP_TIMEOUT;
                            rsp_user            <= '0;
                            rsp_valid           <= 1'b1;
                            state               <= RSP;
                        end
                    end
                end
                AR: if (aximm_client_arready) begin
                    aximm_client_arvalid <= 1'b0;
                    aximm_client_rready  <= 1'b1;
                    to_cnt               <= '0;
                    state                <= R;
                end
                R: begin
                    if (aximm_client_rvalid) begin
                        aximm_client_rready <= 1'b0;
                        rsp_data            <= aximm_client_rdata;
                        rsp_resp            <= read_resp(aximm_client_rlast, aximm_client_rresp);
                        rsp_user            <= aximm_client_ruser;
                        rsp_valid           <= 1'b1;
                        state               <= RSP;
                    end else begin
                        to_cnt <= to_cnt + TOW'(1);
                        if (to_hit) begin
                            aximm_client_rready <= 1'b0;
                            rsp_data            <= '0;
                            rsp_resp            <= RESP_TIMEOUT;
                            rsp_user            <= '0;
                            rsp_valid           <= 1'b1;
                            state               <= RSP;
                        end
                    end
                end
                RSP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
